singleport_mem_arbiter: RTL and testbench

Arbitrates one single-port image RAM (18-bit address, 8-bit data) between two requesters: port 0 is the convolution core's pixel writer, port 1 is a host/readback master.
- Round-robin grant with a registered memory command stage.
- Tracks read latency so each read's data returns to the requester that issued it.
- Counts pixel writes and flags frame completion to the top level, replacing the free-running finish input.

---
 rtl/singleport_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_singleport_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/singleport_mem_arbiter.sv
// Two-port round-robin arbiter for a single-port image RAM with a registered
// command stage, read-return tagging and a frame write counter.
module singleport_mem_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 8,
   parameter int RD_LATENCY   = 1,
   parameter int FRAME_PIXELS = 262144
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_rvalid_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_rvalid_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              frame_clr_i,
   output logic              frame_done_o,
   output logic [ADDR_W:0]   wr_count_o
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PIXELS - 1);

   typedef enum logic {
      LAST_M0 = 1'b0,
      LAST_M1 = 1'b1
   } last_e;

   last_e               last_q, last_d;
   logic                gnt0_s, gnt1_s, xfer0_s, xfer1_s;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_re_q, mem_re_d;
   logic                cmd_tag_q, cmd_tag_d;
   logic [RD_LATENCY-1:0] rv_q, rv_d;
   logic [RD_LATENCY-1:0] rtag_q, rtag_d;
   logic [CW-1:0]       wr_count_q, wr_count_d;
   logic                frame_done_q, frame_done_d;

   // Grant: lone requester wins; on contention the port not granted last wins.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst_ni) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (m0_req_i && m1_req_i) begin
         gnt0_s = (last_q == LAST_M1);
         gnt1_s = (last_q == LAST_M0);
      end else begin
         gnt0_s = m0_req_i;
         gnt1_s = m1_req_i;
      end
   end

   assign xfer0_s = m0_req_i & gnt0_s;
   assign xfer1_s = m1_req_i & gnt1_s;

   // Command stage and pointer: register the winner's access; address/data hold when idle.
   always_comb begin
      last_d      = last_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      cmd_tag_d   = cmd_tag_q;
      if (xfer0_s) begin
         last_d      = LAST_M0;
         mem_addr_d  = m0_addr_i;
         mem_wdata_d = m0_wdata_i;
         mem_we_d    = m0_we_i;
         mem_re_d    = ~m0_we_i;
         cmd_tag_d   = 1'b0;
      end else if (xfer1_s) begin
         last_d      = LAST_M1;
         mem_addr_d  = m1_addr_i;
         mem_wdata_d = m1_wdata_i;
         mem_we_d    = m1_we_i;
         mem_re_d    = ~m1_we_i;
         cmd_tag_d   = 1'b1;
      end else begin
         last_d = last_q;
      end
   end

   // Read-return tracker: one valid/tag stage per RAM latency cycle.
   always_comb begin
      rv_d      = rv_q;
      rtag_d    = rtag_q;
      rv_d[0]   = mem_re_q;
      rtag_d[0] = cmd_tag_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         rv_d[i]   = rv_q[i-1];
         rtag_d[i] = rtag_q[i-1];
      end
   end

   // Frame write counter; a frame-complete set takes priority over a clear.
   always_comb begin
      wr_count_d   = wr_count_q;
      frame_done_d = frame_done_q;
      if (frame_clr_i) begin
         frame_done_d = 1'b0;
      end else begin
         frame_done_d = frame_done_q;
      end
      if (mem_we_q) begin
         if (wr_count_q == CNT_LAST) begin
            wr_count_d   = '0;
            frame_done_d = 1'b1;
         end else begin
            wr_count_d = wr_count_q + CW'(1);
         end
      end else begin
         wr_count_d = wr_count_q;
      end
   end

   // State registers; reset drops any read still in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q       <= LAST_M1;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         cmd_tag_q    <= 1'b0;
         rv_q         <= '0;
         rtag_q       <= '0;
         wr_count_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         last_q       <= last_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         cmd_tag_q    <= cmd_tag_d;
         rv_q         <= rv_d;
         rtag_q       <= rtag_d;
         wr_count_q   <= wr_count_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign m0_gnt_o     = gnt0_s;
   assign m1_gnt_o     = gnt1_s;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign mem_we_o     = mem_we_q;
   assign mem_re_o     = mem_re_q;
   assign m0_rdata_o   = mem_rdata_i;
   assign m1_rdata_o   = mem_rdata_i;
   assign m0_rvalid_o  = rv_q[RD_LATENCY-1] & ~rtag_q[RD_LATENCY-1];
   assign m1_rvalid_o  = rv_q[RD_LATENCY-1] & rtag_q[RD_LATENCY-1];
   assign wr_count_o   = wr_count_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_singleport_mem_arbiter.sv
// Bench for singleport_mem_arbiter: grant table, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_singleport_mem_arbiter;

   localparam int AW  = 18;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int FP  = 4;

   logic          clk, rst_n;
   logic          m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we, mem_re, frame_clr, frame_done;
   logic [AW:0]   wr_count;

   singleport_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .FRAME_PIXELS(FP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
      .mem_rdata_i(mem_rdata), .frame_clr_i(frame_clr), .frame_done_o(frame_done),
      .wr_count_o(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM environment: unwritten locations read as addr+0x30, LAT-cycle read pipe.
   logic [7:0]    tb_ram [0:1023];
   logic [1023:0] tb_wv = '0;
   logic [7:0]    rd_pipe [0:LAT-1];

   function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
      return tb_wv[a[9:0]] ? tb_ram[a[9:0]] : (a[7:0] + 8'h30);
   endfunction

   always @(posedge clk) begin
      rd_pipe[0] <= mem_re ? ram_rd(mem_addr) : 8'h00;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_we) begin
         tb_ram[mem_addr[9:0]] <= mem_wdata;
         tb_wv[mem_addr[9:0]]  <= 1'b1;
      end
   end
   assign mem_rdata = rd_pipe[LAT-1];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: transaction view of the arbiter.
   typedef struct {
      int         due;
      bit         port;
      logic [7:0] data;
   } ret_t;

   bit            m_rst, m_last, m_we, m_re, m_done, x0, x1;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wdata;
   int unsigned   m_writes;
   int            cyc = 0;
   ret_t          m_rq[$];
   logic [7:0]    ref_ram [int];

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_ram.exists(int'(a)) ? ref_ram[int'(a)] : (a[7:0] + 8'h30);
   endfunction

   task automatic model_reset();
      m_last = 1'b1; m_we = 1'b0; m_re = 1'b0; m_addr = '0; m_wdata = '0;
      m_writes = 0; m_done = 1'b0; x0 = 1'b0; x1 = 1'b0;
      m_rq.delete();
   endtask

   task automatic model_step();
      bit e0, e1, ev0, ev1, set_done;
      logic [7:0] ed;
      if (m_rst) begin
         e0 = 1'b0; e1 = 1'b0;
      end else if (m0_req && m1_req) begin
         e0 = m_last; e1 = !m_last;
      end else begin
         e0 = m0_req; e1 = m1_req;
      end
      chk("m0_gnt", 32'(m0_gnt), 32'(e0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e1));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_re", 32'(mem_re), 32'(m_re));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      ev0 = 1'b0; ev1 = 1'b0; ed = 8'h00;
      if (m_rq.size() > 0 && m_rq[0].due == cyc) begin
         ev0 = !m_rq[0].port; ev1 = m_rq[0].port; ed = m_rq[0].data;
         void'(m_rq.pop_front());
      end
      chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
      if (ev0 || ev1) begin
         chk("m0_rdata", 32'(m0_rdata), 32'(ed));
         chk("m1_rdata", 32'(m1_rdata), 32'(ed));
      end
      chk("wr_count", 32'(wr_count), m_writes % FP);
      chk("frame_done", 32'(frame_done), 32'(m_done));
      x0 = 1'b0; x1 = 1'b0;
      if (!m_rst) begin
         set_done = m_we && ((m_writes + 1) % FP == 0);
         if (m_we) m_writes++;
         if (set_done) m_done = 1'b1;
         else if (frame_clr) m_done = 1'b0;
         x0 = e0; x1 = e1;
         if (x0) begin
            m_last = 1'b0; m_we = m0_we; m_re = !m0_we; m_addr = m0_addr; m_wdata = m0_wdata;
            if (m0_we) ref_ram[int'(m0_addr)] = m0_wdata;
            else m_rq.push_back('{cyc + 1 + LAT, 1'b0, ref_rd(m0_addr)});
         end else if (x1) begin
            m_last = 1'b1; m_we = m1_we; m_re = !m1_we; m_addr = m1_addr; m_wdata = m1_wdata;
            if (m1_we) ref_ram[int'(m1_addr)] = m1_wdata;
            else m_rq.push_back('{cyc + 1 + LAT, 1'b1, ref_rd(m1_addr)});
         end else begin
            m_we = 1'b0; m_re = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic setp(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [7:0] d1);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic fin();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      mid();
      fin();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; m_rst = 1'b1; model_reset();
      tick(); tick();
      rst_n = 1'b1; m_rst = 1'b0;
   endtask

   typedef struct {
      bit r0, r1, e0, e1;
   } vec_t;

   vec_t tbl [15];
   int   g0_cnt, g1_cnt;
   bit   pend0, pend1, pw0, pw1;
   logic [AW-1:0] pa0, pa1;
   logic [7:0]    pd0, pd1;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; m_rst = 1'b1; frame_clr = 1'b0;
      model_reset();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      #3;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      @(posedge clk); #1;
      do_reset();

      // Single write from port 0.
      setp(1'b1, 1'b1, 18'h00010, 8'hA5, 1'b0, 1'b0, '0, 8'h00);
      mid(); chk("t1_gnt", 32'(m0_gnt), 32'd1); fin();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      mid();
      chk("t1_mem_we", 32'(mem_we), 32'd1);
      chk("t1_mem_addr", 32'(mem_addr), 32'h10);
      chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
      fin();
      mid(); chk("t1_wr_count", 32'(wr_count), 32'd1); fin();

      // Grant table from a fresh reset: m0 writing, m1 reading.
      do_reset();
      g0_cnt = 0; g1_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         setp(tbl[i].r0, 1'b1, 18'h00100, 8'h5A, tbl[i].r1, 1'b0, 18'h00200, 8'h00);
         mid();
         chk($sformatf("tbl%0d_g0", i), 32'(m0_gnt), 32'(tbl[i].e0));
         chk($sformatf("tbl%0d_g1", i), 32'(m1_gnt), 32'(tbl[i].e1));
         if (i < 8) begin
            g0_cnt += int'(m0_gnt);
            g1_cnt += int'(m1_gnt);
         end
         fin();
      end
      chk("fair_g0", 32'(g0_cnt), 32'd4);
      chk("fair_g1", 32'(g1_cnt), 32'd4);
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      for (int i = 0; i < LAT + 2; i++) tick();

      // Back-to-back m1 reads of 5 and 6.
      setp(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 18'h00005, 8'h00);
      mid(); chk("rd_gnt_a", 32'(m1_gnt), 32'd1); fin();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 18'h00006, 8'h00);
      mid(); chk("rd_gnt_b", 32'(m1_gnt), 32'd1); fin();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      mid(); chk("rd_early", 32'(m1_rvalid), 32'd0); fin();
      mid();
      chk("rd_v_a", 32'(m1_rvalid), 32'd1);
      chk("rd_d_a", 32'(m1_rdata), 32'h35);
      chk("rd_m0v_a", 32'(m0_rvalid), 32'd0);
      fin();
      mid();
      chk("rd_v_b", 32'(m1_rvalid), 32'd1);
      chk("rd_d_b", 32'(m1_rdata), 32'h36);
      chk("rd_m0v_b", 32'(m0_rvalid), 32'd0);
      fin();
      tick();

      // Withdrawal: pointer is last=m1 here.
      setp(1'b1, 1'b1, 18'h00120, 8'h11, 1'b1, 1'b0, 18'h00007, 8'h00);
      mid(); chk("wd_a_g0", 32'(m0_gnt), 32'd1); chk("wd_a_g1", 32'(m1_gnt), 32'd0); fin();
      setp(1'b1, 1'b1, 18'h00121, 8'h12, 1'b0, 1'b0, 18'h00007, 8'h00);
      mid(); chk("wd_b_g1", 32'(m1_gnt), 32'd0); fin();
      setp(1'b1, 1'b1, 18'h00122, 8'h13, 1'b1, 1'b0, 18'h00007, 8'h00);
      mid(); chk("wd_c_g1", 32'(m1_gnt), 32'd1); chk("wd_c_g0", 32'(m0_gnt), 32'd0); fin();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      for (int i = 0; i < LAT + 2; i++) tick();

      // Frame completion, set-beats-clear, clear alone.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         setp(c < 8, 1'b1, 18'h00130 + 18'(c), 8'(c + 8'h40), 1'b0, 1'b0, '0, 8'h00);
         frame_clr = (c == 8) || (c == 10);
         mid();
         if (c == 4) begin
            chk("fr_cnt3", 32'(wr_count), 32'd3);
            chk("fr_done0", 32'(frame_done), 32'd0);
         end
         if (c == 5) begin
            chk("fr_wrap", 32'(wr_count), 32'd0);
            chk("fr_done1", 32'(frame_done), 32'd1);
         end
         if (c == 9) begin
            chk("fr_setwins", 32'(frame_done), 32'd1);
            chk("fr_wrap2", 32'(wr_count), 32'd0);
         end
         if (c == 11) chk("fr_clr", 32'(frame_done), 32'd0);
         fin();
      end
      frame_clr = 1'b0;

      // Reset while a read is in flight.
      setp(1'b1, 1'b1, 18'h00140, 8'h77, 1'b0, 1'b0, '0, 8'h00);
      tick();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 18'h00009, 8'h00);
      mid(); chk("rr_gnt", 32'(m1_gnt), 32'd1); fin();
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      mid();
      chk("rr_re", 32'(mem_re), 32'd1);
      model_step();
      #1 rst_n = 1'b0; m_rst = 1'b1; model_reset();
      #1;
      chk("rr_we0", 32'(mem_we), 32'd0);
      chk("rr_re0", 32'(mem_re), 32'd0);
      chk("rr_addr0", 32'(mem_addr), 32'd0);
      chk("rr_wdata0", 32'(mem_wdata), 32'd0);
      chk("rr_rv0", 32'(m0_rvalid), 32'd0);
      chk("rr_rv1", 32'(m1_rvalid), 32'd0);
      chk("rr_cnt0", 32'(wr_count), 32'd0);
      @(posedge clk); #1;
      tick();
      rst_n = 1'b1; m_rst = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         mid(); chk("rr_no_rv", 32'(m1_rvalid | m0_rvalid), 32'd0); fin();
      end
      setp(1'b1, 1'b1, 18'h00141, 8'h01, 1'b1, 1'b0, 18'h00009, 8'h00);
      mid(); chk("rr_first_g0", 32'(m0_gnt), 32'd1); chk("rr_first_g1", 32'(m1_gnt), 32'd0); fin();

      // Randomized traffic against the model.
      pend0 = 1'b0; pend1 = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (pend0 && x0) pend0 = 1'b0;
         if (pend1 && x1) pend1 = 1'b0;
         if (!pend0 && $urandom_range(0, 99) < 50) begin
            pend0 = 1'b1; pw0 = $urandom_range(0, 1) == 1;
            pa0 = 18'h00020 + 18'($urandom_range(0, 15)); pd0 = 8'($urandom);
         end else if (pend0 && $urandom_range(0, 99) < 5) begin
            pend0 = 1'b0;
         end
         if (!pend1 && $urandom_range(0, 99) < 50) begin
            pend1 = 1'b1; pw1 = $urandom_range(0, 1) == 1;
            pa1 = 18'h00020 + 18'($urandom_range(0, 15)); pd1 = 8'($urandom);
         end else if (pend1 && $urandom_range(0, 99) < 5) begin
            pend1 = 1'b0;
         end
         setp(pend0, pw0, pa0, pd0, pend1, pw1, pa1, pd1);
         frame_clr = ($urandom_range(0, 15) == 0);
         tick();
      end
      setp(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      frame_clr = 1'b0;
      for (int i = 0; i < LAT + 3; i++) tick();
      chk("drain_empty", 32'(m_rq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
